// File: rtl/playlist_ctrl_if.sv
// rtl/playlist_ctrl_if.sv - button/player/status signal bundle for playlist_ctrl
interface playlist_ctrl_if;
  logic       next_btn;
  logic       prev_btn;
  logic       song_finished;
  logic       repeat_all;
  logic       shuffle;
  logic [1:0] song_sel;
  logic       song_change;
  logic       playlist_done;

  modport master (
    output next_btn, prev_btn, song_finished, repeat_all, shuffle,
    input  song_sel, song_change, playlist_done
  );

  modport slave (
    input  next_btn, prev_btn, song_finished, repeat_all, shuffle,
    output song_sel, song_change, playlist_done
  );
endinterface

// File: rtl/playlist_ctrl.sv
// rtl/playlist_ctrl.sv - playlist sequencer with post-change holdoff
// Optional random song order is built only when PLAYLIST_SHUFFLE_EN is defined.
module playlist_ctrl #(
  parameter int NUM_SONGS = 4,
  parameter int HOLDOFF   = 4
) (
  input logic            clk,
  input logic            reset,
  playlist_ctrl_if.slave bus
);
  typedef enum logic [1:0] {PLAYING = 2'd0, HOLD = 2'd1, STOPPED = 2'd2} state_t;

  localparam logic [1:0] LAST_SONG = 2'(NUM_SONGS - 1);
  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF);

  state_t     state_q, state_d;
  logic [1:0] song_sel_q, song_sel_d;
  logic       song_change_q, song_change_d;
  logic       playlist_done_q, playlist_done_d;
  logic       song_finished_q, song_finished_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;

  logic       finish_evt, next_evt, prev_evt;
  logic [1:0] seq_next, seq_prev;
  logic [1:0] fin_sel, nxt_sel;
  logic       fin_stop;
  logic       do_change;
  logic [1:0] new_sel;

  assign finish_evt = bus.song_finished & ~song_finished_q;
  assign next_evt   = bus.next_btn & ~bus.prev_btn;
  assign prev_evt   = bus.prev_btn & ~bus.next_btn;
  assign seq_next   = (song_sel_q == LAST_SONG) ? 2'd0 : song_sel_q + 2'd1;
  assign seq_prev   = (song_sel_q == 2'd0) ? LAST_SONG : song_sel_q - 2'd1;

`ifdef PLAYLIST_SHUFFLE_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [2:0] played_q, played_d, played_inc;
  logic [1:0] cand, shuf_sel;
  logic       played_full;

  assign lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign cand        = 2'(int'(lfsr_q[1:0]) % NUM_SONGS);
  // Never re-pick the song that just played.
  assign shuf_sel    = (cand == song_sel_q) ? 2'((int'(cand) + 1) % NUM_SONGS) : cand;
  assign played_inc  = played_q + 3'd1;
  assign played_full = (played_inc == 3'(NUM_SONGS));

  always_comb begin
    fin_sel  = seq_next;
    nxt_sel  = seq_next;
    fin_stop = (song_sel_q == LAST_SONG) && !bus.repeat_all;
    if (bus.shuffle) begin
      fin_sel  = shuf_sel;
      nxt_sel  = shuf_sel;
      fin_stop = played_full && !bus.repeat_all;
    end
  end
`else
  logic shuffle_unused;
  assign shuffle_unused = bus.shuffle;

  always_comb begin
    fin_sel  = seq_next;
    nxt_sel  = seq_next;
    fin_stop = (song_sel_q == LAST_SONG) && !bus.repeat_all;
  end
`endif

  always_comb begin
    state_d         = state_q;
    song_sel_d      = song_sel_q;
    song_change_d   = 1'b0;
    song_finished_d = bus.song_finished;
    hold_cnt_d      = hold_cnt_q;
    do_change       = 1'b0;
    new_sel         = song_sel_q;
`ifdef PLAYLIST_SHUFFLE_EN
    played_d        = played_q;
`endif
    case (state_q)
      PLAYING: begin
        // A finish outranks any button press in the same cycle.
        if (finish_evt) begin
          if (fin_stop) begin
            state_d = STOPPED;
          end else begin
            do_change = 1'b1;
            new_sel   = fin_sel;
          end
`ifdef PLAYLIST_SHUFFLE_EN
          if (bus.shuffle) played_d = played_full ? 3'd0 : played_inc;
`endif
        end else if (next_evt) begin
          do_change = 1'b1;
          new_sel   = nxt_sel;
        end else if (prev_evt) begin
          do_change = 1'b1;
          new_sel   = seq_prev;
        end
      end
      HOLD: begin
        if (hold_cnt_q == 4'd0) state_d = PLAYING;
        else hold_cnt_d = hold_cnt_q - 4'd1;
      end
      STOPPED: begin
        if (next_evt || prev_evt) begin
          do_change = 1'b1;
          new_sel   = 2'd0;
`ifdef PLAYLIST_SHUFFLE_EN
          played_d  = 3'd0;
`endif
        end
      end
      default: state_d = HOLD;
    endcase

    if (do_change) begin
      song_sel_d    = new_sel;
      song_change_d = 1'b1;
      state_d       = HOLD;
      hold_cnt_d    = HOLD_LOAD;
    end
    playlist_done_d = (state_d == STOPPED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= HOLD;
      song_sel_q      <= 2'd0;
      song_change_q   <= 1'b0;
      playlist_done_q <= 1'b0;
      song_finished_q <= 1'b0;
      hold_cnt_q      <= HOLD_LOAD;
`ifdef PLAYLIST_SHUFFLE_EN
      lfsr_q          <= 8'hA5;
      played_q        <= 3'd0;
`endif
    end else begin
      state_q         <= state_d;
      song_sel_q      <= song_sel_d;
      song_change_q   <= song_change_d;
      playlist_done_q <= playlist_done_d;
      song_finished_q <= song_finished_d;
      hold_cnt_q      <= hold_cnt_d;
`ifdef PLAYLIST_SHUFFLE_EN
      lfsr_q          <= lfsr_d;
      played_q        <= played_d;
`endif
    end
  end

  assign bus.song_sel      = song_sel_q;
  assign bus.song_change   = song_change_q;
  assign bus.playlist_done = playlist_done_q;
endmodule

// File: tb/tb_playlist_ctrl.sv
// tb/tb_playlist_ctrl.sv - scoreboard bench for playlist_ctrl, directed and random stimulus
module tb_playlist_ctrl;
  localparam int NS = 4;
  localparam int HO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  playlist_ctrl_if bus();

  playlist_ctrl #(.NUM_SONGS(NS), .HOLDOFF(HO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_no;
    bit is_stop;
    int sel;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: time-based view of the playlist rules.
  int m_sel, m_last;
  bit m_stop, m_fprev;
  bit cur_rp;

  always @(posedge clk) cyc++;

  function automatic void chk(string nm, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp_v);
    end
  endfunction

  function automatic void push_change(int e, int s);
    m_sel  = s;
    m_last = e;
    q.push_back('{e, 1'b0, s});
  endfunction

  function automatic void model_step(int e, bit nb, bit pb, bit sf, bit rp);
    bit fin;
    fin     = sf && !m_fprev;
    m_fprev = sf;
    if (e - m_last <= HO + 1) return;
    if (m_stop) begin
      if (nb ^ pb) begin
        m_stop = 1'b0;
        push_change(e, 0);
      end
      return;
    end
    if (fin) begin
      if (m_sel < NS - 1) push_change(e, m_sel + 1);
      else if (rp) push_change(e, 0);
      else begin
        m_stop = 1'b1;
        q.push_back('{e, 1'b1, m_sel});
      end
    end else if (nb && !pb) begin
      push_change(e, (m_sel + 1) % NS);
    end else if (pb && !nb) begin
      push_change(e, (m_sel + NS - 1) % NS);
    end
  endfunction

  task automatic drive(input bit nb, input bit pb, input bit sf, input bit rp);
    bus.next_btn      = nb;
    bus.prev_btn      = pb;
    bus.song_finished = sf;
    bus.repeat_all    = rp;
    bus.shuffle       = 1'($urandom_range(0, 1));
    cur_rp            = rp;
    model_step(cyc + 1, nb, pb, sf, rp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, cur_rp);
  endtask

  task automatic do_reset(input int n);
    reset             = 1'b1;
    bus.next_btn      = 1'b0;
    bus.prev_btn      = 1'b0;
    bus.song_finished = 1'b0;
    bus.shuffle       = 1'b0;
    bus.repeat_all    = cur_rp;
    q.delete();
    repeat (n) @(posedge clk);
    #1;
    reset   = 1'b0;
    m_sel   = 0;
    m_stop  = 1'b0;
    m_fprev = 1'b0;
    m_last  = cyc;
  endtask

  task automatic finish_pulse(input bit rp, input bit nb, input bit pb);
    drive(nb, pb, 1'b1, rp);
    drive(1'b0, 1'b0, 1'b0, rp);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a change or a stop.
  int   sh_sel = 0;
  bit   sh_done = 1'b0;
  bit   got_evt;
  exp_t ev;

  always @(negedge clk) begin
    if (reset) begin
      chk("reset_song_sel", int'(bus.song_sel), 0);
      chk("reset_song_change", int'(bus.song_change), 0);
      chk("reset_playlist_done", int'(bus.playlist_done), 0);
      sh_sel  = 0;
      sh_done = 1'b0;
    end else begin
      while (q.size() > 0 && q[0].edge_no < cyc) begin
        ev = q.pop_front();
        chk("stale_expected_event", cyc, ev.edge_no);
      end
      got_evt = bus.song_change || (bus.playlist_done && !sh_done);
      if (q.size() > 0 && q[0].edge_no == cyc) begin
        ev = q.pop_front();
        chk("event_seen", int'(got_evt), 1);
        chk("event_song_change", int'(bus.song_change), int'(!ev.is_stop));
        chk("event_song_sel", int'(bus.song_sel), ev.sel);
        sh_sel  = ev.sel;
        sh_done = ev.is_stop;
      end else begin
        chk("unexpected_event", int'(got_evt), 0);
      end
      chk("song_sel_level", int'(bus.song_sel), sh_sel);
      chk("playlist_done_level", int'(bus.playlist_done), int'(sh_done));
    end
  end

  initial begin
    cur_rp = 1'b0;
    do_reset(3);

    // Holdoff after reset, then sequential finishes to STOPPED.
    idle(HO + 1);
    chk("after_reset_sel", int'(bus.song_sel), 0);
    for (int i = 0; i < NS; i++) begin
      finish_pulse(1'b0, 1'b0, 1'b0);
      idle(HO + 1);
    end
    chk("stopped_sel", int'(bus.song_sel), NS - 1);
    chk("stopped_done", int'(bus.playlist_done), 1);
    finish_pulse(1'b0, 1'b0, 1'b0);
    chk("stopped_ignores_finish", int'(bus.playlist_done), 1);

    // Restart from STOPPED, then reset in the middle of the holdoff.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_sel", int'(bus.song_sel), 0);
    chk("restart_done", int'(bus.playlist_done), 0);
    chk("restart_change", int'(bus.song_change), 1);
    idle(1);
    do_reset(2);
    chk("midhold_reset_change", int'(bus.song_change), 0);
    idle(HO + 1);

    // prev wrap, simultaneous buttons, button during holdoff.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(HO);
    chk("prev_wrap_sel", int'(bus.song_sel), NS - 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("both_buttons_sel", int'(bus.song_sel), NS - 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(HO + 1);
    chk("next_wrap_sel", int'(bus.song_sel), 0);

    // repeat_all wrap from the last song.
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    idle(HO + 1);
    finish_pulse(1'b1, 1'b0, 1'b0);
    idle(HO);
    chk("repeat_wrap_sel", int'(bus.song_sel), 0);

    // Finish outranks prev in the same cycle.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(HO + 1);
    finish_pulse(1'b0, 1'b0, 1'b1);
    idle(HO);
    chk("finish_priority_sel", int'(bus.song_sel), 2);

    // Randomized phase.
    begin
      bit sf = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 399) == 0) begin
          do_reset($urandom_range(1, 3));
          sf = 1'b0;
        end
        if ($urandom_range(0, 4) == 0) sf = ~sf;
        if ($urandom_range(0, 49) == 0) cur_rp = ~cur_rp;
        drive(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0), sf, cur_rp);
      end
    end

    idle(HO + 3);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/playlist_ctrl.md
PLAYLIST_CTRL -- requirements
Module: playlist_ctrl

Interface
REQ-001 SHALL have parameter NUM_SONGS, default 4, number of songs in the playlist (legal range 2..4).
REQ-002 SHALL have parameter HOLDOFF, default 4, number of clk cycles after a song change during which finish and button events are ignored (legal range 1..15).
REQ-003 SHALL have port clk  input  1  clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port next_btn  input  1  single-cycle pulse requesting the next song.
REQ-006 SHALL have port prev_btn  input  1  single-cycle pulse requesting the previous song.
REQ-007 SHALL have port song_finished  input  1  end-of-song indication from the player controller, sampled level.
REQ-008 SHALL have port repeat_all  input  1  level; 1 = wrap to song 0 after the last song.
REQ-009 SHALL have port shuffle  input  1  level; 1 = random next-song selection.
REQ-010 SHALL have port song_sel  output  2  current song index, registered.
REQ-011 SHALL have port song_change  output  1  one-cycle pulse, registered, high in the cycle song_sel takes a new value.
REQ-012 SHALL have port playlist_done  output  1  registered level, high while in STOPPED.

Function
REQ-013 SHALL implement states PLAYING, HOLD, STOPPED; the reset state SHALL be HOLD with song_sel=0.
REQ-014 SHALL detect song_finished by rising edge: finish_evt = song_finished & ~song_finished_q.
REQ-015 In PLAYING, finish_evt SHALL select the next song: song_sel+1 if song_sel<NUM_SONGS-1; 0 if song_sel=NUM_SONGS-1 and repeat_all=1; otherwise enter STOPPED with song_sel unchanged.
REQ-016 In PLAYING, next_btn alone SHALL set song_sel to song_sel+1, wrapping from NUM_SONGS-1 to 0 regardless of repeat_all.
REQ-017 In PLAYING, prev_btn alone SHALL set song_sel to song_sel-1, wrapping from 0 to NUM_SONGS-1.
REQ-018 next_btn and prev_btn high in the same cycle SHALL be ignored.
REQ-019 finish_evt SHALL take priority over any button event in the same cycle.
REQ-020 Every song_sel change SHALL pulse song_change for exactly one cycle and enter HOLD with the holdoff counter loaded with HOLDOFF.
REQ-021 HOLD SHALL decrement the counter each cycle, ignore finish_evt, next_btn and prev_btn, and enter PLAYING the cycle after the counter reaches 0.
REQ-022 In STOPPED, next_btn or prev_btn (not both) SHALL set song_sel=0, pulse song_change, clear playlist_done, and enter HOLD; finish_evt SHALL be ignored.
REQ-023 playlist_done SHALL rise in the same cycle STOPPED is entered.
REQ-024 A change in repeat_all SHALL take effect on the next finish_evt only.

Reset
REQ-025 Reset SHALL force song_sel=0, song_change=0, playlist_done=0, song_finished_q=0, holdoff counter=HOLDOFF, and state HOLD.
REQ-026 Reset asserted mid-HOLD or in STOPPED SHALL abandon the operation without emitting song_change.

Configuration
REQ-027 Macro PLAYLIST_SHUFFLE_EN: when defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 at reset) SHALL advance every cycle.
REQ-028 With PLAYLIST_SHUFFLE_EN defined and shuffle=1, finish_evt or next_btn SHALL select cand = lfsr[1:0] mod NUM_SONGS, or (cand+1) mod NUM_SONGS if cand equals song_sel.
REQ-029 With PLAYLIST_SHUFFLE_EN defined and shuffle=1, a 3-bit played counter SHALL count finish_evt advances; at count NUM_SONGS with repeat_all=0 the block SHALL enter STOPPED; the counter SHALL clear on reset and on leaving STOPPED.
REQ-030 Without PLAYLIST_SHUFFLE_EN, the shuffle port SHALL remain present and be ignored, and no LFSR or played counter SHALL be built.

Verification
REQ-031 Reset, then wait HOLDOFF+1 cycles -> song_sel=0, state PLAYING, song_change never high.
REQ-032 repeat_all=0; pulse song_finished once per song from song 0 -> song_sel steps 1,2,3, each with one song_change pulse; on the 4th finish, playlist_done=1 and song_sel stays 3.
REQ-033 repeat_all=1, song_sel=3, finish_evt -> song_sel=0 and song_change=1 for one cycle.
REQ-034 song_sel=0, prev_btn -> song_sel=3; next_btn and prev_btn together -> no change; next_btn during HOLD -> ignored.
REQ-035 song_sel=1, finish_evt and prev_btn in the same cycle -> song_sel=2.
REQ-036 In STOPPED, next_btn -> song_sel=0, playlist_done=0, HOLD entered; assert reset mid-HOLD -> all outputs return to reset values with no song_change pulse.
